// File: rtl/rv32i_pkg.sv
// Shared RV32I register-file types: datapath widths, write-port arbiter state
// and the write-request bundle.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef enum logic [0:0] {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rf_fwd_mux.sv
// One read port's bypass: returns the staged write when it targets the same
// register, else the raw register file data.
module rf_fwd_mux #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            stage_valid,
  input  logic [AW-1:0]   stage_rd,
  input  logic [XLEN-1:0] stage_data,
  input  logic [AW-1:0]   rs,
  input  logic [XLEN-1:0] op_rf,
  output logic [XLEN-1:0] op
);

  // x0 never matches: stage_valid is cleared for rd == 0 writes.
  assign op = (stage_valid && (rs == stage_rd)) ? stage_data : op_rf;

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register file write port between core writeback and debug,
// stages the winner for one cycle and forwards it to both read ports.
module rf_write_arbiter
  import rv32i_pkg::*;
#(
  parameter int XLEN         = rv32i_pkg::XLEN,
  parameter int AW           = rv32i_pkg::AW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            dbg_valid,
  output logic            dbg_ready,
  input  logic [AW-1:0]   dbg_rd,
  input  logic [XLEN-1:0] dbg_data,
  output logic            rf_enable,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_data,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [XLEN-1:0] op_a_rf,
  input  logic [XLEN-1:0] op_b_rf,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic            starved
);

  // state      | meaning
  // ARB_NORMAL | wb has priority, scnt counts consecutive dbg losses
  // ARB_FORCE  | dbg granted unconditionally for one accept, wb held off

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  arb_state_t state, state_nxt;
  logic [3:0] scnt, scnt_nxt;
  logic       accept;
  wr_req_t    win;
  logic       stage_valid;
  wr_req_t    stage;

  always_comb begin
    wb_ready  = 1'b0;
    dbg_ready = 1'b0;
    if (!rst) begin
      if (state == ARB_FORCE)
        dbg_ready = dbg_valid;
      else if (wb_valid)
        wb_ready = 1'b1;
      else
        dbg_ready = dbg_valid;
    end
    accept = wb_ready || dbg_ready;
    win    = wb_ready ? '{rd: wb_rd, data: wb_data} : '{rd: dbg_rd, data: dbg_data};
  end

  // FORCE is entered the cycle after the LIM-th consecutive loss, so dbg
  // wins on every (LIM+1)-th cycle under sustained contention.
  always_comb begin
    scnt_nxt  = 4'd0;
    state_nxt = ARB_NORMAL;
    if (state == ARB_NORMAL) begin
      if (dbg_valid && !dbg_ready)
        scnt_nxt = (scnt == LIM) ? scnt : scnt + 4'd1;
      if (scnt_nxt == LIM)
        state_nxt = ARB_FORCE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB_NORMAL;
      scnt        <= 4'd0;
      starved     <= 1'b0;
      stage_valid <= 1'b0;
      stage       <= '0;
    end else begin
      state       <= state_nxt;
      scnt        <= scnt_nxt;
      starved     <= (state_nxt == ARB_FORCE);
      stage_valid <= accept && (win.rd != '0);
      if (accept)
        stage <= win;
    end
  end

  assign rf_enable = stage_valid;
  assign rf_rd     = stage.rd;
  assign rf_data   = stage.data;

  rf_fwd_mux #(.XLEN(XLEN), .AW(AW)) u_fwd_a (
    .stage_valid (stage_valid),
    .stage_rd    (stage.rd),
    .stage_data  (stage.data),
    .rs          (rs1),
    .op_rf       (op_a_rf),
    .op          (op_a)
  );

  rf_fwd_mux #(.XLEN(XLEN), .AW(AW)) u_fwd_b (
    .stage_valid (stage_valid),
    .stage_rd    (stage.rd),
    .stage_data  (stage.data),
    .rs          (rs2),
    .op_rf       (op_b_rf),
    .op          (op_b)
  );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, forwarding, x0 drop,
// starvation, back-to-back writes and reset during a staged write.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        dbg_valid, dbg_ready;
  logic [4:0]  dbg_rd;
  logic [31:0] dbg_data;
  logic        rf_enable;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic [4:0]  rs1, rs2;
  logic [31:0] op_a_rf, op_b_rf, op_a, op_b;
  logic        starved;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.XLEN(32), .AW(5), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_rd(dbg_rd), .dbg_data(dbg_data),
    .rf_enable(rf_enable), .rf_rd(rf_rd), .rf_data(rf_data),
    .rs1(rs1), .rs2(rs2), .op_a_rf(op_a_rf), .op_b_rf(op_b_rf),
    .op_a(op_a), .op_b(op_b), .starved(starved)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h9;
    dbg_valid = 1'b1; dbg_rd = 5'd6; dbg_data = 32'h66;
    rs1 = 5'd2; op_a_rf = 32'd77; rs2 = 5'd0; op_b_rf = 32'd0;
    step(); step();
    #2;
    n_vec++; if (wb_ready !== 1'b0) begin n_err++; $display("FAIL rst_wb_ready got=%b exp=0", wb_ready); end
    n_vec++; if (dbg_ready !== 1'b0) begin n_err++; $display("FAIL rst_dbg_ready got=%b exp=0", dbg_ready); end
    n_vec++; if (rf_enable !== 1'b0) begin n_err++; $display("FAIL rst_rf_enable got=%b exp=0", rf_enable); end
    n_vec++; if (rf_rd !== 5'd0) begin n_err++; $display("FAIL rst_rf_rd got=%0d exp=0", rf_rd); end
    n_vec++; if (rf_data !== 32'd0) begin n_err++; $display("FAIL rst_rf_data got=%h exp=0", rf_data); end
    n_vec++; if (starved !== 1'b0) begin n_err++; $display("FAIL rst_starved got=%b exp=0", starved); end
    n_vec++; if (op_a !== 32'd77) begin n_err++; $display("FAIL rst_op_a got=%0d exp=77", op_a); end
    step();
    rst = 1'b0;
    dbg_valid = 1'b0;
    #2;
    n_vec++; if (wb_ready !== 1'b1) begin n_err++; $display("FAIL rel_wb_ready got=%b exp=1", wb_ready); end
    step();
    wb_valid = 1'b0;
    n_vec++; if (rf_enable !== 1'b1) begin n_err++; $display("FAIL rel_rf_enable got=%b exp=1", rf_enable); end
    n_vec++; if (rf_rd !== 5'd2) begin n_err++; $display("FAIL rel_rf_rd got=%0d exp=2", rf_rd); end
    n_vec++; if (rf_data !== 32'h9) begin n_err++; $display("FAIL rel_rf_data got=%h exp=9", rf_data); end
    n_vec++; if (op_a !== 32'h9) begin n_err++; $display("FAIL rel_fwd_a got=%h exp=9", op_a); end
    step();
  endtask

  task automatic test_single_write();
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h1;
    #2;
    n_vec++; if (wb_ready !== 1'b1) begin n_err++; $display("FAIL single_ready got=%b exp=1", wb_ready); end
    step();
    wb_valid = 1'b0; rs1 = 5'd1; op_a_rf = 32'h0;
    #1;
    n_vec++; if (rf_enable !== 1'b1) begin n_err++; $display("FAIL single_rf_enable got=%b exp=1", rf_enable); end
    n_vec++; if (rf_rd !== 5'd1) begin n_err++; $display("FAIL single_rf_rd got=%0d exp=1", rf_rd); end
    n_vec++; if (op_a !== 32'h1) begin n_err++; $display("FAIL single_fwd_a got=%h exp=1", op_a); end
    step();
    op_a_rf = 32'h55;
    #1;
    n_vec++; if (rf_enable !== 1'b0) begin n_err++; $display("FAIL single_idle_enable got=%b exp=0", rf_enable); end
    n_vec++; if (op_a !== 32'h55) begin n_err++; $display("FAIL single_no_fwd got=%h exp=55", op_a); end
  endtask

  task automatic test_x0_drop();
    dbg_valid = 1'b1; dbg_rd = 5'd0; dbg_data = 32'hDEAD;
    #2;
    n_vec++; if (dbg_ready !== 1'b1) begin n_err++; $display("FAIL x0_dbg_ready got=%b exp=1", dbg_ready); end
    n_vec++; if (wb_ready !== 1'b0) begin n_err++; $display("FAIL x0_wb_ready got=%b exp=0", wb_ready); end
    step();
    dbg_valid = 1'b0; rs2 = 5'd0; op_b_rf = 32'd123; rs1 = 5'd0; op_a_rf = 32'd321;
    #1;
    n_vec++; if (rf_enable !== 1'b0) begin n_err++; $display("FAIL x0_rf_enable got=%b exp=0", rf_enable); end
    n_vec++; if (op_b !== 32'd123) begin n_err++; $display("FAIL x0_op_b got=%0d exp=123", op_b); end
    n_vec++; if (op_a !== 32'd321) begin n_err++; $display("FAIL x0_op_a got=%0d exp=321", op_a); end
    step();
  endtask

  task automatic test_starvation();
    logic exp_dbg;
    wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'hA0;
    dbg_valid = 1'b1; dbg_rd = 5'd11; dbg_data = 32'hB0;
    for (int k = 0; k < 10; k++) begin
      exp_dbg = (k == 4) || (k == 9);
      #2;
      n_vec++; if (wb_ready !== !exp_dbg) begin n_err++; $display("FAIL starve_wb_ready cyc=%0d got=%b exp=%b", k, wb_ready, !exp_dbg); end
      n_vec++; if (dbg_ready !== exp_dbg) begin n_err++; $display("FAIL starve_dbg_ready cyc=%0d got=%b exp=%b", k, dbg_ready, exp_dbg); end
      n_vec++; if (starved !== exp_dbg) begin n_err++; $display("FAIL starve_flag cyc=%0d got=%b exp=%b", k, starved, exp_dbg); end
      step();
      n_vec++; if (rf_rd !== (exp_dbg ? 5'd11 : 5'd10)) begin n_err++; $display("FAIL starve_rf_rd cyc=%0d got=%0d exp=%0d", k, rf_rd, exp_dbg ? 11 : 10); end
    end
    wb_valid = 1'b0; dbg_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    rs1 = 5'd0; op_a_rf = 32'd0;
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1'b1; wb_rd = 5'(3 + i); wb_data = 32'(5 + i);
      step();
      rs1 = 5'(3 + i);
      #1;
      n_vec++; if (rf_enable !== 1'b1) begin n_err++; $display("FAIL b2b_enable i=%0d got=%b exp=1", i, rf_enable); end
      n_vec++; if (rf_rd !== 5'(3 + i)) begin n_err++; $display("FAIL b2b_rf_rd i=%0d got=%0d exp=%0d", i, rf_rd, 3 + i); end
      n_vec++; if (rf_data !== 32'(5 + i)) begin n_err++; $display("FAIL b2b_rf_data i=%0d got=%0d exp=%0d", i, rf_data, 5 + i); end
      n_vec++; if (op_a !== 32'(5 + i)) begin n_err++; $display("FAIL b2b_fwd_a i=%0d got=%0d exp=%0d", i, op_a, 5 + i); end
    end
    wb_valid = 1'b0;
    step();
    n_vec++; if (rf_enable !== 1'b0) begin n_err++; $display("FAIL b2b_tail_enable got=%b exp=0", rf_enable); end
  endtask

  task automatic test_reset_mid();
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hA5A5A5A5;
    dbg_valid = 1'b1; dbg_rd = 5'd9; dbg_data = 32'h99;
    step();
    wb_rd = 5'd8; wb_data = 32'h88;
    step();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (rf_enable !== 1'b0) begin n_err++; $display("FAIL mid_rf_enable k=%0d got=%b exp=0", k, rf_enable); end
      n_vec++; if (starved !== 1'b0) begin n_err++; $display("FAIL mid_starved k=%0d got=%b exp=0", k, starved); end
      step();
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #2;
      n_vec++; if (wb_ready !== (k < 4)) begin n_err++; $display("FAIL mid_wb_ready cyc=%0d got=%b exp=%b", k, wb_ready, k < 4); end
      n_vec++; if (dbg_ready !== (k == 4)) begin n_err++; $display("FAIL mid_dbg_ready cyc=%0d got=%b exp=%b", k, dbg_ready, k == 4); end
      step();
      n_vec++; if (rf_rd === 5'd7 && rf_enable === 1'b1) begin n_err++; $display("FAIL mid_r7_leak cyc=%0d got=r7 exp=not_r7", k); end
    end
    wb_valid = 1'b0; dbg_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_x0_drop();
    test_starvation();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
